// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// riscv_pkg : shared fetch-path types and constants
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
//------------------------------------------------------------------------------
// fetch_skid_buffer : 2-entry FIFO of {pc, instr} with flush and occupancy
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output fetch_entry_t head
);

    fetch_entry_t entry0_q;
    fetch_entry_t entry1_q;
    fetch_entry_t hold_q;
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   occ_q;
    fetch_entry_t cur_head;

    assign cur_head = rd_ptr_q ? entry1_q : entry0_q;

    // When empty, present the most recently shown head so decode sees stable data.
    assign head = (occ_q != 2'd0) ? cur_head : hold_q;
    assign occ  = occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            hold_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (occ_q != 2'd0) begin
                hold_q <= cur_head;
            end
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                occ_q    <= 2'd0;
            end else begin
                if (push) begin
                    if (wr_ptr_q) begin
                        entry1_q <= push_data;
                    end else begin
                        entry0_q <= push_data;
                    end
                    wr_ptr_q <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && !pop && (occ_q == 2'd2)));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// instruction_fetch : PC generation, in-flight tracking and fetch issue control
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic [1:0]      occ;
    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      pending;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign pop  = if_valid & if_ready;
    assign push = inflight_q & ~redirect_valid;

    // Slots that will be claimed after this edge; issue only if one stays free.
    assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = fetch_en & ~redirect_valid & (pending <= 3'd1);

    assign push_entry.pc    = req_pc_q;
    assign push_entry.instr = imem_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
        end else if (issue) begin
            req_pc_q   <= pc_q;
            inflight_q <= 1'b1;
            pc_q       <= pc_q + PC_STEP;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    fetch_skid_buffer u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop & ~redirect_valid),
        .occ       (occ),
        .head      (head_entry)
    );

    assign imem_pc  = pc_q;
    assign if_valid = (occ != 2'd0);
    assign if_pc    = head_entry.pc;
    assign if_instr = head_entry.instr;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// tb_instruction_fetch : directed + random checks against a queue-based model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int vectors;
    int miscompares;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory: data for address A appears one cycle after A is driven.
    initial imem_instr = 32'h0;
    always @(posedge clk) imem_instr <= 32'hA000_0000 | imem_pc;

    // Reference model: pending instruction PCs in order, one request in flight.
    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_infl       = 1'b0;
        m_infl_pc    = 32'h0;
        m_pc         = 32'h0;
        m_last_pc    = 32'h0;
        m_last_instr = 32'h0;
    endtask

    task automatic model_update(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit pop;
        bit iss;
        int pend;
        pop = (mq.size() != 0) && rdy;
        if (mq.size() != 0) begin
            m_last_pc    = mq[0];
            m_last_instr = mem_word(mq[0]);
        end
        if (rv) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = rpc & 32'hFFFF_FFFC;
        end else begin
            pend = mq.size() + int'(m_infl) - int'(pop);
            iss  = fe && (pend <= 1);
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (iss) begin
                m_infl    = 1'b1;
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (mq.size() != 0);
        chk("if_valid", {31'b0, if_valid}, {31'b0, v});
        chk("imem_pc", imem_pc, m_pc);
        chk("if_pc", if_pc, v ? mq[0] : m_last_pc);
        chk("if_instr", if_instr, v ? mem_word(mq[0]) : m_last_instr);
        chk("occ_bound", {31'b0, mq.size() > 2}, 32'h0);
    endtask

    // Called at a negative edge: drive, check, advance one cycle.
    task automatic step(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        model_update(fe, rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit fe, input bit rdy);
        for (int i = 0; i < n; i++) step(fe, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, then first entry accepted followed by a 5-cycle stall
        run(3, 1'b1, 1'b1);
        run(5, 1'b1, 1'b0);
        run(6, 1'b1, 1'b1);

        // Fill the buffer, then redirect to 0x40
        run(2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
        run(6, 1'b1, 1'b1);

        // Misaligned redirect
        step(1'b1, 1'b1, 32'h0000_0046, 1'b1);
        run(5, 1'b1, 1'b1);

        // Fetch disabled mid-stream, then resumed
        run(4, 1'b0, 1'b1);
        run(5, 1'b1, 1'b1);

        // Redirect near the top of the address space to exercise wrap
        step(1'b1, 1'b1, 32'hFFFF_FFF4, 1'b1);
        run(7, 1'b1, 1'b1);

        // Back-to-back redirects: last wins
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        run(5, 1'b1, 1'b1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(5, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit          fe;
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            fe  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            step(fe, rv, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
